// File: rtl/tbce_pkg.sv
// tbce_pkg: shared rate encodings, FSM states and puncture helpers for the TBCE.
// Revision: 1.0
`default_nettype none

package tbce_pkg;

  localparam logic [1:0] RATE_1_2 = 2'd0;
  localparam logic [1:0] RATE_2_3 = 2'd1;
  localparam logic [1:0] RATE_3_4 = 2'd2;

  localparam int         K_DEF  = 7;
  localparam logic [6:0] G0_DEF = 7'o133;
  localparam logic [6:0] G1_DEF = 7'o171;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Returns {keepA, keepB}; the reserved rate code behaves as rate 1/2.
  function automatic logic [1:0] punct_mask(input logic [1:0] rate, input logic [1:0] phase);
    logic [1:0] m;
    m = 2'b11;
    case (rate)
      RATE_2_3: if (phase == 2'd1) m = 2'b10;
      RATE_3_4: begin
        if (phase == 2'd1)      m = 2'b10;
        else if (phase == 2'd2) m = 2'b01;
      end
      default:  m = 2'b11;
    endcase
    return m;
  endfunction

  function automatic logic [1:0] punct_period(input logic [1:0] rate);
    logic [1:0] p;
    case (rate)
      RATE_2_3: p = 2'd2;
      RATE_3_4: p = 2'd3;
      default:  p = 2'd1;
    endcase
    return p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tbce_punct_ser.sv
// tbce_punct_ser: coded-pair buffer and one-bit-per-cycle serializer with a registered output.
// Revision: 1.0
`default_nettype none

module tbce_punct_ser (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       a_i,
  input  logic       b_i,
  input  logic [1:0] keep_i,
  input  logic       last_i,
  output logic       free_o,
  output logic       dout_o,
  output logic       dout_vld_o,
  output logic       dout_last_o,
  input  logic       dout_rdy_i
);

  logic dout_q, dout_d;
  logic vld_q, vld_d;
  logic dlast_q, dlast_d;
  logic sec_q, sec_d;
  logic b_q, b_d;
  logic blast_q, blast_d;
  logic w_hs;

  assign w_hs   = vld_q & dout_rdy_i;
  // Free once nothing is pending behind the presented bit and that bit is leaving.
  assign free_o = ~sec_q & (~vld_q | dout_rdy_i);

  always_comb begin
    dout_d  = dout_q;
    vld_d   = vld_q;
    dlast_d = dlast_q;
    sec_d   = sec_q;
    b_d     = b_q;
    blast_d = blast_q;
    if (load_i) begin
      if (keep_i[1]) begin
        dout_d  = a_i;
        vld_d   = 1'b1;
        dlast_d = last_i & ~keep_i[0];
        sec_d   = keep_i[0];
        b_d     = b_i;
        blast_d = last_i;
      end else begin
        dout_d  = b_i;
        vld_d   = 1'b1;
        dlast_d = last_i;
        sec_d   = 1'b0;
      end
    end else if (w_hs) begin
      if (sec_q) begin
        dout_d  = b_q;
        vld_d   = 1'b1;
        dlast_d = blast_q;
        sec_d   = 1'b0;
      end else begin
        dout_d  = 1'b0;
        vld_d   = 1'b0;
        dlast_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q  <= 1'b0;
      vld_q   <= 1'b0;
      dlast_q <= 1'b0;
      sec_q   <= 1'b0;
      b_q     <= 1'b0;
      blast_q <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      dlast_q <= dlast_d;
      sec_q   <= sec_d;
      b_q     <= b_d;
      blast_q <= blast_d;
    end
  end

  assign dout_o      = dout_q;
  assign dout_vld_o  = vld_q;
  assign dout_last_o = dlast_q;

endmodule

`default_nettype wire

// File: rtl/tbce_punct.sv
// tbce_punct: tail-biting convolutional encoder with runtime-selectable 802.11a puncturing.
// Revision: 1.0
`default_nettype none

module tbce_punct
  import tbce_pkg::*;
#(
  parameter int           K     = K_DEF,
  parameter logic [K-1:0] G0    = G0_DEF,
  parameter logic [K-1:0] G1    = G1_DEF,
  parameter int           LEN_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [LEN_W-1:0] blk_len_i,
  input  logic [1:0]       rate_i,
  input  logic [K-2:0]     din_init_i,
  input  logic             din_i,
  input  logic             din_vld_i,
  output logic             din_rdy_o,
  output logic             dout_o,
  output logic             dout_vld_o,
  input  logic             dout_rdy_i,
  output logic             dout_last_o,
  output logic             busy_o,
  output logic             tb_err_o
);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [1:0]       rate_q, rate_d;
  logic [1:0]       phase_q, phase_d;
  logic [K-2:0]     init_q, init_d;
  logic [K-2:0]     sr_q, sr_d;
  logic             tb_err_q, tb_err_d;

  logic [K-1:0]     w_u;
  logic [K-2:0]     w_sr_next;
  logic             w_a, w_b;
  logic [1:0]       w_keep;
  logic             w_free;
  logic             w_acc;
  logic             w_last_bit;
  logic             w_fin;

  // MSB of u is the current bit (delay 0), matching the generator tap order.
  assign w_u        = {din_i, sr_q};
  assign w_a        = ^(w_u & G0);
  assign w_b        = ^(w_u & G1);
  assign w_sr_next  = {din_i, sr_q[K-2:1]};
  assign w_keep     = punct_mask(rate_q, phase_q);
  assign din_rdy_o  = (state_q == ST_RUN) & w_free;
  assign w_acc      = din_vld_i & din_rdy_o;
  assign w_last_bit = (cnt_q == len_q - LEN_W'(1));
  assign w_fin      = dout_vld_o & dout_rdy_i & dout_last_o;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    rate_d   = rate_q;
    phase_d  = phase_q;
    init_d   = init_q;
    sr_d     = sr_q;
    tb_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i && (blk_len_i != '0)) begin
          state_d = ST_RUN;
          len_d   = blk_len_i;
          rate_d  = rate_i;
          init_d  = din_init_i;
          sr_d    = din_init_i;
          cnt_d   = '0;
          phase_d = 2'd0;
        end
      end
      ST_RUN: begin
        if (w_acc) begin
          sr_d    = w_sr_next;
          cnt_d   = cnt_q + LEN_W'(1);
          phase_d = (phase_q == punct_period(rate_q) - 2'd1) ? 2'd0 : phase_q + 2'd1;
          if (w_last_bit) begin
            state_d  = ST_DRAIN;
            // A tail-biting block must wrap back to the state it started from.
            tb_err_d = (w_sr_next != init_q);
          end
        end
      end
      ST_DRAIN: begin
        if (w_fin) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      rate_q   <= 2'd0;
      phase_q  <= 2'd0;
      init_q   <= '0;
      sr_q     <= '0;
      tb_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      rate_q   <= rate_d;
      phase_q  <= phase_d;
      init_q   <= init_d;
      sr_q     <= sr_d;
      tb_err_q <= tb_err_d;
    end
  end

  tbce_punct_ser u_ser (
    .clk         (clk),
    .rst         (rst),
    .load_i      (w_acc),
    .a_i         (w_a),
    .b_i         (w_b),
    .keep_i      (w_keep),
    .last_i      (w_last_bit),
    .free_o      (w_free),
    .dout_o      (dout_o),
    .dout_vld_o  (dout_vld_o),
    .dout_last_o (dout_last_o),
    .dout_rdy_i  (dout_rdy_i)
  );

  assign busy_o   = (state_q != ST_IDLE);
  assign tb_err_o = tb_err_q;

endmodule

`default_nettype wire

// File: tb/tb_tbce_punct.sv
// tb_tbce_punct: directed self-checking bench for tbce_punct (K=7, 133/171).
// Revision: 1.0
`default_nettype none

module tb_tbce_punct;

  localparam logic [6:0] TG0 = 7'o133;
  localparam logic [6:0] TG1 = 7'o171;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] blk_len;
  logic [1:0]  rate;
  logic [5:0]  din_init;
  logic        din, din_vld, din_rdy;
  logic        dout, dout_vld, dout_rdy, dout_last;
  logic        busy, tb_err;

  always #5 clk = ~clk;

  tbce_punct dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .blk_len_i   (blk_len),
    .rate_i      (rate),
    .din_init_i  (din_init),
    .din_i       (din),
    .din_vld_i   (din_vld),
    .din_rdy_o   (din_rdy),
    .dout_o      (dout),
    .dout_vld_o  (dout_vld),
    .dout_rdy_i  (dout_rdy),
    .dout_last_o (dout_last),
    .busy_o      (busy),
    .tb_err_o    (tb_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  bit          data_a [0:63];
  int          n_bits;
  logic [1:0]  r_rate;
  logic [5:0]  r_init;
  int          rdy_mode;

  logic [127:0] got_v;
  int           got_n, last_idx, n_last, err_n, stall_bad, rdy_bad;
  bit           err_ok, done;

  task automatic load_vec(input logic [63:0] v, input int n);
    for (int i = 0; i < 64; i++) data_a[i] = v[i];
    n_bits = n;
  endtask

  // Reference: taps read directly from bit history, wrapping into din_init before bit 0.
  task automatic model(input int n, input logic [1:0] r, input logic [5:0] init,
                       output logic [127:0] ev, output int en);
    ev = '0;
    en = 0;
    for (int i = 0; i < n; i++) begin
      logic a, b, x;
      int   p, ph;
      a = 1'b0;
      b = 1'b0;
      for (int d = 0; d < 7; d++) begin
        if (d == 0)          x = data_a[i];
        else if (i - d >= 0) x = data_a[i-d];
        else                 x = init[6+i-d];
        a = a ^ (x & TG0[6-d]);
        b = b ^ (x & TG1[6-d]);
      end
      p  = (r == 2'd1) ? 2 : (r == 2'd2) ? 3 : 1;
      ph = i % p;
      if (!(r == 2'd2 && ph == 2)) begin ev = {ev[126:0], a}; en++; end
      if (ph != 1)                 begin ev = {ev[126:0], b}; en++; end
    end
  endtask

  function automatic logic rdy_pat(input int cyc);
    if (rdy_mode == 0) return 1'b1;
    if (cyc >= 8 && cyc <= 12) return 1'b0;
    return (cyc % 2) == 0;
  endfunction

  task automatic run_block(input int restart_at);
    int   cyc, idx, last_acc_cyc;
    logic prev_stall, p_dout, p_last;
    got_v = '0; got_n = 0; last_idx = -1; n_last = 0; err_n = 0;
    stall_bad = 0; rdy_bad = 0; err_ok = 1'b0; done = 1'b0;
    prev_stall = 1'b0; p_dout = 1'b0; p_last = 1'b0; last_acc_cyc = -10;
    start = 1'b1; blk_len = 12'(n_bits); rate = r_rate; din_init = r_init;
    din_vld = 1'b0; dout_rdy = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0;
    cyc = 0;
    while (!done && cyc < 2000) begin
      dout_rdy = rdy_pat(cyc);
      din_vld  = (idx < n_bits);
      din      = (idx < 64) ? data_a[idx] : 1'b0;
      start    = (cyc == restart_at);
      if (cyc == restart_at) begin
        blk_len = 12'd3; rate = 2'd2; din_init = 6'h3F;
      end
      #1;
      if (prev_stall && (dout !== p_dout || dout_last !== p_last || dout_vld !== 1'b1)) stall_bad++;
      if (dout_vld && !dout_rdy && din_rdy) rdy_bad++;
      if (tb_err) begin
        err_n++;
        if (cyc == last_acc_cyc + 1) err_ok = 1'b1;
      end
      if (din_vld && din_rdy) begin
        idx++;
        if (idx == n_bits) last_acc_cyc = cyc;
      end
      if (dout_vld && dout_rdy) begin
        got_v = {got_v[126:0], dout};
        if (dout_last) begin n_last++; last_idx = got_n; done = 1'b1; end
        got_n++;
      end
      prev_stall = dout_vld && !dout_rdy;
      p_dout = dout;
      p_last = dout_last;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    din_vld = 1'b0;
    check("block_done", done, 1'b1);
  endtask

  task automatic check_block(input string tag, input logic [127:0] ev, input int en);
    check({tag, "_data"}, got_v, ev);
    check({tag, "_count"}, got_n, en);
    check({tag, "_last_idx"}, last_idx, en - 1);
    check({tag, "_last_once"}, n_last, 1);
  endtask

  initial begin
    logic [127:0] ev, gold;
    logic [63:0]  v48;
    int           en, acc, idle_vld;

    rst = 1'b1; start = 1'b0; blk_len = '0; rate = '0; din_init = '0;
    din = 1'b0; din_vld = 1'b0; dout_rdy = 1'b1; rdy_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {din_rdy, dout, dout_vld, dout_last, busy, tb_err}, 6'b0);
    rst = 1'b0;

    // start with zero length stays idle
    start = 1'b1; blk_len = 12'd0;
    @(posedge clk); #1;
    start = 1'b0;
    check("zero_len_busy", busy, 1'b0);
    @(posedge clk); #1;
    check("zero_len_idle", {busy, din_rdy, dout_vld}, 3'b0);

    // impulse, rate 1/2
    load_vec(64'h1, 8); r_rate = 2'd0; r_init = 6'h00;
    run_block(-1);
    check_block("imp12", 128'hDF2C, 16);
    check("imp12_tberr", err_n, 0);

    // impulse, rate 3/4
    load_vec(64'h1, 8); r_rate = 2'd2; r_init = 6'h00;
    run_block(-1);
    check_block("imp34", 128'b11011100110, 11);

    // 48-bit tail-biting block, with an ignored start mid-run
    v48 = 64'h0000_A5C3_96F0_1E7B;
    load_vec(v48, 48); r_rate = 2'd0; r_init = v48[47:42];
    model(48, 2'd0, r_init, gold, en);
    run_block(5);
    check_block("tb_ok", gold, en);
    check("tb_ok_err", err_n, 0);

    // corrupted initial state
    r_init = v48[47:42] ^ 6'b000001;
    model(48, 2'd0, r_init, ev, en);
    run_block(-1);
    check_block("tb_bad", ev, en);
    check("tb_bad_err_count", err_n, 1);
    check("tb_bad_err_time", err_ok, 1'b1);
    check("tb_bad_first_pair", got_v[95:94], gold[95:94] ^ 2'b11);

    // backpressure, rate 2/3
    load_vec(64'hB2E, 12); r_rate = 2'd1; r_init = 6'h15; rdy_mode = 1;
    model(12, 2'd1, r_init, ev, en);
    run_block(-1);
    rdy_mode = 0;
    check_block("bp23", ev, 18);
    check("bp23_stable", stall_bad, 0);
    check("bp23_din_rdy", rdy_bad, 0);

    // reset at input bit 5 aborts the block
    load_vec(64'hC9, 8);
    start = 1'b1; blk_len = 12'd8; rate = 2'd0; din_init = 6'h00;
    @(posedge clk); #1;
    start = 1'b0; din_vld = 1'b1; dout_rdy = 1'b1; acc = 0;
    for (int c = 0; c < 100; c++) begin
      din = data_a[acc];
      #1;
      if (din_vld && din_rdy) acc++;
      if (acc == 5) rst = 1'b1;
      @(posedge clk); #1;
      if (rst) break;
    end
    check("abort_reached", acc, 5);
    check("abort_outputs", {din_rdy, dout, dout_vld, dout_last, busy, tb_err}, 6'b0);
    rst = 1'b0; din_vld = 1'b0;
    idle_vld = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (dout_vld || busy) idle_vld++;
    end
    check("abort_quiet", idle_vld, 0);
    load_vec(64'h1, 8); r_rate = 2'd0; r_init = 6'h00;
    run_block(-1);
    check_block("post_abort", 128'hDF2C, 16);

    // back-to-back blocks with different rates
    load_vec(64'h2D3, 10); r_rate = 2'd2; r_init = 6'h2A;
    model(10, 2'd2, r_init, ev, en);
    run_block(-1);
    check_block("b2b_a", ev, 14);
    load_vec(64'h5B, 7); r_rate = 2'd1; r_init = 6'h07;
    model(7, 2'd1, r_init, ev, en);
    run_block(-1);
    check_block("b2b_b", ev, 11);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
